// File: rtl/sys_array_split_core_if.sv
// Operand/result bundle for sys_array_split_core; the core takes the slave side.
// start_comp is a level: its rising edge while the core is idle or done launches one run;
// ready=1 means out_data holds the finished product and stays valid until the next accepted start.
interface sys_array_split_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_A_W  = 4,
  parameter int ARRAY_A_L  = 5,
  parameter int ARRAY_W_W  = 5,
  parameter int ARRAY_W_L  = 8
);
  logic                                          start_comp;
  logic [ARRAY_A_W*ARRAY_A_L*DATA_WIDTH-1:0]     input_data_a;
  logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0]     weights;
  logic                                          ready;
  logic [ARRAY_A_W*ARRAY_W_L*2*DATA_WIDTH-1:0]   out_data;
  logic [2:0]                                    fsm_state;

  modport master (output start_comp, output input_data_a, output weights,
                  input ready, input out_data, input fsm_state);
  modport slave  (input start_comp, input input_data_a, input weights,
                  output ready, output out_data, output fsm_state);
endinterface

// File: rtl/sys_array_split_core.sv
// Signed C = A x W on a weight-stationary systolic MAC grid, one W tile at a time.
// Macro SYS_ARRAY_ACC_SATURATE_EN makes every accumulation step saturate instead of wrap.
module sys_array_split_core #(
  parameter int DATA_WIDTH    = 8,
  parameter int ARRAY_A_W     = 4,
  parameter int ARRAY_A_L     = 5,
  parameter int ARRAY_W_W     = 5,
  parameter int ARRAY_W_L     = 8,
  parameter int ARRAY_W       = 5,
  parameter int ARRAY_L       = 5,
  parameter int ARRAY_MAX_A_W = 5,
  parameter int OUT_SIZE      = 100
) (
  input logic                   clk,
  input logic                   reset,
  sys_array_split_core_if.slave bus
);
  localparam int PW        = 2 * DATA_WIDTH;
  localparam int NTR       = (ARRAY_W_W + ARRAY_W - 1) / ARRAY_W;
  localparam int NTC       = (ARRAY_W_L + ARRAY_L - 1) / ARRAY_L;
  localparam int FD        = ARRAY_A_W + ARRAY_W + ARRAY_L - 1;
  localparam int FEED_LAST = ARRAY_A_W + ARRAY_W - 2;
  localparam int CW        = $clog2(FD + 1);
  localparam int RW        = $clog2(NTR + 1);
  localparam int KW        = $clog2(NTC + 1);

  if (ARRAY_A_L != ARRAY_W_W) begin : g_chk_inner
    $error("ARRAY_A_L must equal ARRAY_W_W");
  end
  if (ARRAY_A_W > ARRAY_MAX_A_W) begin : g_chk_rows
    $error("ARRAY_A_W exceeds ARRAY_MAX_A_W");
  end
  if (ARRAY_A_W * ARRAY_W_L > OUT_SIZE) begin : g_chk_size
    $error("result does not fit in OUT_SIZE");
  end

`ifdef SYS_ARRAY_ACC_SATURATE_EN
  localparam logic signed [PW-1:0] ACC_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] ACC_MIN = {1'b1, {(PW-1){1'b0}}};
`endif

  function automatic logic signed [PW-1:0] acc_add(input logic signed [PW-1:0] x,
                                                   input logic signed [PW-1:0] y);
`ifdef SYS_ARRAY_ACC_SATURATE_EN
    logic [PW:0] s;
    s = {x[PW-1], x} + {y[PW-1], y};
    if (s[PW] != s[PW-1]) return s[PW] ? ACC_MIN : ACC_MAX;
    return s[PW-1:0];
`else
    return x + y;
`endif
  endfunction

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, ACCUM, DONE} state_t;
  state_t state_q, state_d;

  logic          start_q, accept, last_tile, busy_pe;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] kt_q;
  logic [KW-1:0] ct_q;
  logic          ready_q;
  logic [ARRAY_A_W*ARRAY_W_L*PW-1:0] out_q;

  logic signed [DATA_WIDTH-1:0] a_m    [ARRAY_A_W][ARRAY_A_L];
  logic signed [DATA_WIDTH-1:0] w_m    [ARRAY_W_W][ARRAY_W_L];
  logic signed [DATA_WIDTH-1:0] w_tile [ARRAY_W][ARRAY_L];
  logic signed [DATA_WIDTH-1:0] feed   [ARRAY_W];
  logic signed [DATA_WIDTH-1:0] a_out  [ARRAY_W][ARRAY_L];
  logic signed [PW-1:0]         ps_out [ARRAY_W][ARRAY_L];
  logic signed [PW-1:0]         tres   [ARRAY_A_W][ARRAY_L];
  logic signed [PW-1:0]         acc    [ARRAY_A_W][ARRAY_W_L];

  assign accept    = bus.start_comp && !start_q && (state_q == IDLE || state_q == DONE);
  assign last_tile = (kt_q == RW'(NTR - 1)) && (ct_q == KW'(NTC - 1));
  assign busy_pe   = (state_q == FEED) || (state_q == DRAIN);

  assign bus.ready     = ready_q;
  assign bus.out_data  = out_q;
  assign bus.fsm_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = FEED;
      FEED:    if (cnt_q == CW'(FEED_LAST)) state_d = (FEED_LAST == FD - 1) ? ACCUM : DRAIN;
      DRAIN:   if (cnt_q == CW'(FD - 1)) state_d = ACCUM;
      ACCUM:   state_d = last_tile ? DONE : LOAD;
      DONE:    if (accept) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Tile order: row tile (kt) outer, column tile (ct) inner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      cnt_q   <= '0;
      kt_q    <= '0;
      ct_q    <= '0;
    end else begin
      start_q <= bus.start_comp;
      if (accept) begin
        kt_q <= '0;
        ct_q <= '0;
      end else if (state_q == ACCUM && !last_tile) begin
        if (ct_q == KW'(NTC - 1)) begin
          ct_q <= '0;
          kt_q <= kt_q + RW'(1);
        end else begin
          ct_q <= ct_q + KW'(1);
        end
      end
      if (state_q == LOAD) cnt_q <= '0;
      else if (busy_pe)    cnt_q <= cnt_q + CW'(1);
    end
  end

  // Operand snapshot, weight tile load (zero-padded) and bottom-row result capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < ARRAY_A_W; r++)
        for (int c = 0; c < ARRAY_A_L; c++)
          a_m[r][c] <= bus.input_data_a[(r*ARRAY_A_L+c)*DATA_WIDTH +: DATA_WIDTH];
      for (int k = 0; k < ARRAY_W_W; k++)
        for (int n = 0; n < ARRAY_W_L; n++)
          w_m[k][n] <= bus.weights[(k*ARRAY_W_L+n)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (state_q == LOAD) begin
      for (int i = 0; i < ARRAY_W; i++)
        for (int j = 0; j < ARRAY_L; j++) begin
          w_tile[i][j] <= '0;
          for (int k = 0; k < ARRAY_W_W; k++)
            for (int n = 0; n < ARRAY_W_L; n++)
              if (k == int'(kt_q)*ARRAY_W + i && n == int'(ct_q)*ARRAY_L + j)
                w_tile[i][j] <= w_m[k][n];
        end
    end
    // Row r of column j leaves the bottom PE register at count r + ARRAY_W + j.
    if (busy_pe) begin
      for (int r = 0; r < ARRAY_A_W; r++)
        for (int j = 0; j < ARRAY_L; j++)
          if (int'(cnt_q) == r + ARRAY_W + j) tres[r][j] <= ps_out[ARRAY_W-1][j];
    end
  end

  // PE row i sees A row r at count r + i; out-of-range A columns feed zero.
  always_comb begin
    for (int i = 0; i < ARRAY_W; i++) begin
      feed[i] = '0;
      for (int r = 0; r < ARRAY_A_W; r++)
        for (int k = 0; k < ARRAY_A_L; k++)
          if (state_q == FEED && int'(cnt_q) == r + i && k == int'(kt_q)*ARRAY_W + i)
            feed[i] = a_m[r][k];
    end
  end

  for (genvar gi = 0; gi < ARRAY_W; gi++) begin : g_row
    for (genvar gj = 0; gj < ARRAY_L; gj++) begin : g_col
      logic signed [DATA_WIDTH-1:0] a_x, a_r;
      logic signed [PW-1:0]         p_x, p_r, prod;
      if (gj == 0) begin : g_lft
        assign a_x = feed[gi];
      end else begin : g_mid
        assign a_x = a_out[gi][gj-1];
      end
      if (gi == 0) begin : g_top
        assign p_x = '0;
      end else begin : g_dn
        assign p_x = ps_out[gi-1][gj];
      end
      assign prod = PW'(a_x) * PW'(w_tile[gi][gj]);
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_r <= '0;
          p_r <= '0;
        end else if (state_q == LOAD) begin
          a_r <= '0;
          p_r <= '0;
        end else if (busy_pe) begin
          a_r <= a_x;
          p_r <= acc_add(p_x, prod);
        end
      end
      assign a_out[gi][gj]  = a_r;
      assign ps_out[gi][gj] = p_r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      out_q   <= '0;
      for (int r = 0; r < ARRAY_A_W; r++)
        for (int c = 0; c < ARRAY_W_L; c++) acc[r][c] <= '0;
    end else if (accept) begin
      ready_q <= 1'b0;
      for (int r = 0; r < ARRAY_A_W; r++)
        for (int c = 0; c < ARRAY_W_L; c++) acc[r][c] <= '0;
    end else if (state_q == ACCUM) begin
      for (int r = 0; r < ARRAY_A_W; r++)
        for (int c = 0; c < ARRAY_W_L; c++)
          for (int j = 0; j < ARRAY_L; j++)
            if (c == int'(ct_q)*ARRAY_L + j) acc[r][c] <= acc_add(acc[r][c], tres[r][j]);
    end else if (state_q == DONE) begin
      ready_q <= 1'b1;
      for (int r = 0; r < ARRAY_A_W; r++)
        for (int c = 0; c < ARRAY_W_L; c++)
          out_q[(r*ARRAY_W_L+c)*PW +: PW] <= acc[r][c];
    end
  end
endmodule

// File: tb/tb_sys_array_split_core.sv
// Directed bench for sys_array_split_core: latency, products, start filtering, reset abort.
`timescale 1ns/1ps
module tb_sys_array_split_core;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int AL  = 5;
  localparam int WW  = 5;
  localparam int WL  = 8;
  localparam int PW  = 2 * DW;
  localparam int LAT = 31;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  int   bad;
  logic [PW-1:0] exp_q[$];
  logic [AW*WL*PW-1:0] snap;
  int   a_v [AW][AL];
  int   w_v [WW][WL];

  sys_array_split_core_if #(.DATA_WIDTH(DW), .ARRAY_A_W(AW), .ARRAY_A_L(AL),
                            .ARRAY_W_W(WW), .ARRAY_W_L(WL)) bus ();

  sys_array_split_core #(.DATA_WIDTH(DW), .ARRAY_A_W(AW), .ARRAY_A_L(AL),
                         .ARRAY_W_W(WW), .ARRAY_W_L(WL), .ARRAY_W(5), .ARRAY_L(5),
                         .ARRAY_MAX_A_W(5), .OUT_SIZE(100))
    dut (.clk(clk), .reset(reset), .bus(bus));

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // drivers
  task automatic pack_ops();
    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) bus.input_data_a[(r*AL+c)*DW +: DW] = DW'(a_v[r][c]);
    for (int k = 0; k < WW; k++)
      for (int n = 0; n < WL; n++) bus.weights[(k*WL+n)*DW +: DW] = DW'(w_v[k][n]);
  endtask

  task automatic run(input int hold_n, input int busy_n, input bit scramble, output int l);
    l = -1;
    bus.start_comp = 1'b1;
    for (int n = 0; n < LAT + 20; n++) begin
      @(posedge clk); #1;
      if (n == 0) check("ready_drop", bus.ready, 0);
      if (bus.ready === 1'b1) begin
        l = n;
        break;
      end
      bus.start_comp = (n < hold_n) || (n == busy_n);
      if (scramble && n == 0) begin
        bus.input_data_a = {5{$urandom}};
        bus.weights      = {10{$urandom}};
      end
    end
    bus.start_comp = 1'b0;
  endtask

  // scoreboard
  task automatic push_model();
    for (int r = 0; r < AW; r++)
      for (int c = 0; c < WL; c++) begin
        logic signed [PW-1:0] s;
        s = '0;
        for (int k = 0; k < AL; k++) s = s + PW'(a_v[r][k] * w_v[k][c]);
        exp_q.push_back(s);
      end
  endtask

  task automatic compare_out(input string tag);
    for (int r = 0; r < AW; r++)
      for (int c = 0; c < WL; c++) begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        check($sformatf("%s_c%0d_%0d", tag, r, c),
              $signed(bus.out_data[(r*WL+c)*PW +: PW]), $signed(e));
      end
  endtask

  initial begin
    reset = 1'b1;
    bus.start_comp   = 1'b0;
    bus.input_data_a = '0;
    bus.weights      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.ready, 0);
    check("rst_out_or", |bus.out_data, 0);
    check("rst_state", bus.fsm_state, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // A[r][c]=r+c, W[k][n]=k-n
    for (int r = 0; r < AW; r++) for (int c = 0; c < AL; c++) a_v[r][c] = r + c;
    for (int k = 0; k < WW; k++) for (int n = 0; n < WL; n++) w_v[k][n] = k - n;
    pack_ops();
    push_model();
    run(0, -1, 1'b0, lat);
    check("t1_latency", lat, LAT);
    check("t1_c00_const", $signed(bus.out_data[PW-1:0]), 30);
    check("t1_done_state", bus.fsm_state, 5);
    compare_out("t1");

    // all -128 operands, started from DONE
    for (int r = 0; r < AW; r++) for (int c = 0; c < AL; c++) a_v[r][c] = -128;
    for (int k = 0; k < WW; k++) for (int n = 0; n < WL; n++) w_v[k][n] = -128;
    pack_ops();
    for (int i = 0; i < AW*WL; i++) begin
`ifdef SYS_ARRAY_ACC_SATURATE_EN
      exp_q.push_back(16'sd32767);
`else
      exp_q.push_back(16'sd16384);
`endif
    end
    run(0, -1, 1'b0, lat);
    check("t2_latency", lat, LAT);
    compare_out("t2");

    // start held 6 cycles plus an extra edge while busy
    for (int r = 0; r < AW; r++) for (int c = 0; c < AL; c++) a_v[r][c] = r*3 - c*2 + 1;
    for (int k = 0; k < WW; k++) for (int n = 0; n < WL; n++) w_v[k][n] = (k*n) % 5 - 2;
    pack_ops();
    push_model();
    run(5, 10, 1'b0, lat);
    check("t3_latency", lat, LAT);
    compare_out("t3");
    snap = bus.out_data;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.ready !== 1'b1 || bus.out_data !== snap) bad++;
    end
    check("t3_one_run_stable", bad, 0);

    // identity in W columns 0-4, zeros in 5-7; operands scrambled after capture
    for (int r = 0; r < AW; r++) for (int c = 0; c < AL; c++) a_v[r][c] = r*25 - c*30 + 7;
    for (int k = 0; k < WW; k++) for (int n = 0; n < WL; n++) w_v[k][n] = (k == n) ? 1 : 0;
    pack_ops();
    for (int r = 0; r < AW; r++)
      for (int c = 0; c < WL; c++) exp_q.push_back((c < AL) ? PW'(a_v[r][c]) : '0);
    run(0, -1, 1'b1, lat);
    check("t4_latency", lat, LAT);
    compare_out("t4");

    // reset 10 cycles into a run
    for (int r = 0; r < AW; r++) for (int c = 0; c < AL; c++) a_v[r][c] = r + c;
    for (int k = 0; k < WW; k++) for (int n = 0; n < WL; n++) w_v[k][n] = k - n;
    pack_ops();
    bus.start_comp = 1'b1;
    @(posedge clk); #1;
    bus.start_comp = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t5_abort_ready", bus.ready, 0);
    check("t5_abort_out_or", |bus.out_data, 0);
    check("t5_abort_state", bus.fsm_state, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    push_model();
    run(0, -1, 1'b0, lat);
    check("t5_latency", lat, LAT);
    compare_out("t5");

    // new start from DONE with fresh operands, scrambled after capture
    for (int r = 0; r < AW; r++) for (int c = 0; c < AL; c++) a_v[r][c] = 20 - r*c*3;
    for (int k = 0; k < WW; k++) for (int n = 0; n < WL; n++) w_v[k][n] = (k + n) % 4 - 1;
    pack_ops();
    push_model();
    run(0, -1, 1'b1, lat);
    check("t6_latency", lat, LAT);
    compare_out("t6");

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
